// File: rtl/passthru_arb_pkg.sv
// Shared types and helpers for the round-robin pass-through arbiter.
package passthru_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int SRC_W       = $clog2(DEF_NUM_REQ);
  localparam int EXT_MAX_W   = 64;

  // Sign- or zero-extend the low in_w bits of d to the full EXT_MAX_W width.
  function automatic logic [EXT_MAX_W-1:0] ext_data(input logic [EXT_MAX_W-1:0] d,
                                                     input int in_w,
                                                     input logic is_signed);
    logic [EXT_MAX_W-1:0] r;
    logic fill;
    fill = is_signed & d[in_w-1];
    for (int i = 0; i < EXT_MAX_W; i++) begin
      r[i] = (i < in_w) ? d[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: first set request at or after ptr_i, wrapping at NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int SW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SW-1:0]      ptr_i,
  output logic [SW-1:0]      winner_o,
  output logic               any_valid_o
);

  logic [SW:0]   sum;
  logic [SW-1:0] idx;

  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (SW+1)'(k);
      if (sum >= (SW+1)'(NUM_REQ)) sum = sum - (SW+1)'(NUM_REQ);
      idx = sum[SW-1:0];
      if (!any_valid_o && req_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/passthru_rr_arbiter.sv
// Round-robin arbiter with packet locking feeding one registered, width-extending output lane.
module passthru_rr_arbiter
  import passthru_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IN_WIDTH  = 29,
  parameter int OUT_WIDTH = 32,
  localparam int SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_signed,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_last,
  output logic [SW-1:0]               out_src,
  output logic                        busy
);

  arb_state_e           state_q, state_d;
  logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]        gnt_q, gnt_d;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_last_q;
  logic [SW-1:0]        out_src_q;

  logic [SW-1:0]        pick_winner, winner, next_ptr;
  logic                 pick_any, have_grant, can_load, accept;
  logic [IN_WIDTH-1:0]  sel_data;
  logic                 sel_signed, sel_last;
  logic [EXT_MAX_W-1:0] wide, ext_wide;

  rr_picker #(.NUM_REQ(NUM_REQ), .SW(SW)) u_picker (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .winner_o   (pick_winner),
    .any_valid_o(pick_any)
  );

  // While locked the granted requester keeps ready even if it drops valid.
  always_comb begin
    winner     = (state_q == LOCK) ? gnt_q : pick_winner;
    have_grant = (state_q == LOCK) || pick_any;
    can_load   = !out_valid_q || out_ready;
    req_ready  = '0;
    sel_data   = '0;
    sel_signed = 1'b0;
    sel_last   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (SW'(i) == winner) begin
        req_ready[i] = have_grant && can_load && !rst;
        sel_data     = req_data[i*IN_WIDTH +: IN_WIDTH];
        sel_signed   = req_signed[i];
        sel_last     = req_last[i];
      end
    end
    accept = |(req_valid & req_ready);
    wide   = '0;
    wide[IN_WIDTH-1:0] = sel_data;
    ext_wide = ext_data(wide, IN_WIDTH, sel_signed);
    next_ptr = (winner == SW'(NUM_REQ-1)) ? '0 : winner + SW'(1);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_d = next_ptr;
          end else begin
            state_d = LOCK;
            gnt_d   = winner;
          end
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ext_wide[OUT_WIDTH-1:0];
        out_last_q  <= sel_last;
        out_src_q   <= winner;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_passthru_rr_arbiter.sv
// Scoreboard bench: packet-level reference model predicts grants and beats; monitor checks the output lane.
module tb_passthru_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 29;
  localparam int OW = 32;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
    logic [1:0]    s;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_signed, req_last;
  logic [N*IW-1:0] req_data;
  logic            out_valid, out_ready, out_last, busy;
  logic [OW-1:0]   out_data;
  logic [1:0]      out_src;

  int errors = 0;
  int checks = 0;

  beat_t exp_q[$];

  bit m_locked, m_ov, m_prev_rst;
  int m_gnt, m_ptr;

  always #5 clk = ~clk;

  passthru_rr_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_signed(req_signed), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension as integer arithmetic: a negative signed value is d - 2^IW, taken modulo 2^OW.
  function automatic logic [OW-1:0] mext(input logic [IW-1:0] d, input logic s);
    longint v;
    v = longint'(d);
    if (s && d[IW-1]) v = v - (longint'(1) << IW);
    return v[OW-1:0];
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N*IW-1:0] d, input logic [N-1:0] sg,
                      input logic [N-1:0] lst, input logic ordy, input logic r);
    int cand;
    bit can;
    logic [N-1:0] exp_rdy;
    beat_t b;
    @(posedge clk);
    #1;
    req_valid = v; req_data = d; req_signed = sg; req_last = lst; out_ready = ordy; rst = r;
    @(negedge clk);
    if (rst) begin
      chk("ready_in_rst", 64'(req_ready), 64'(0));
      if (m_prev_rst) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
      end
      exp_q.delete();
      m_locked = 0; m_ov = 0; m_gnt = 0; m_ptr = 0; m_prev_rst = 1;
    end else begin
      m_prev_rst = 0;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("busy", 64'(busy), 64'(m_locked));
      can  = !m_ov || out_ready;
      cand = -1;
      if (m_locked) cand = m_gnt;
      else begin
        for (int k = 0; k < N; k++) begin
          if (cand < 0 && req_valid[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
        end
      end
      exp_rdy = (can && cand >= 0) ? N'(1 << cand) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (can && cand >= 0 && req_valid[cand]) begin
        b.d = mext(req_data[cand*IW +: IW], req_signed[cand]);
        b.l = req_last[cand];
        b.s = 2'(cand);
        exp_q.push_back(b);
        if (req_last[cand]) begin
          m_locked = 0;
          m_ptr = (cand + 1) % N;
        end else begin
          m_locked = 1;
          m_gnt = cand;
        end
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  bit            stall_prev = 0;
  logic [OW-1:0] sv_d;
  logic          sv_l;
  logic [1:0]    sv_s;
  always @(negedge clk) begin
    beat_t e;
    if (rst !== 1'b0) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(sv_d));
        chk("stall_last", 64'(out_last), 64'(sv_l));
        chk("stall_src", 64'(out_src), 64'(sv_s));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_last", 64'(out_last), 64'(e.l));
          chk("out_src", 64'(out_src), 64'(e.s));
        end
      end
      stall_prev = out_valid && !out_ready;
      sv_d = out_data; sv_l = out_last; sv_s = out_src;
    end
  end

  initial begin
    logic [N*IW-1:0] d;
    logic [N*IW-1:0] d0;
    rst = 1'b1; req_valid = '1; req_data = '0; req_signed = '0; req_last = '1; out_ready = 1'b1;
    m_prev_rst = 0;
    d = '0;
    for (int i = 0; i < N; i++) d[i*IW +: IW] = IW'(32'h0100_0000 * (i + 1));

    // Reset with everything valid, then round-robin over single-beat packets.
    step('1, d, '0, '1, 1'b1, 1'b1);
    step('1, d, '0, '1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step('1, d, '0, '1, 1'b1, 1'b0);

    // Requester 1 owns the lane for a 3-beat packet while 0 and 2 stay valid.
    step(4'b0111, d, '0, 4'b0101, 1'b1, 1'b0);
    step(4'b0111, d, '0, 4'b0101, 1'b1, 1'b0);
    step(4'b0111, d, '0, 4'b0111, 1'b1, 1'b0);
    step(4'b0111, d, '0, 4'b0111, 1'b1, 1'b0);
    step(4'b0000, d, '0, 4'b0000, 1'b1, 1'b0);

    // Extension of a negative-looking 29-bit value, signed then unsigned.
    step('0, d, '0, '0, 1'b1, 1'b1);
    d0 = d;
    d0[0 +: IW] = 29'h1000_0000;
    step(4'b0001, d0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    step(4'b0000, d0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("sext_const", 64'(out_data), 64'(32'hF000_0000));
    step(4'b0001, d0, 4'b0000, 4'b0001, 1'b1, 1'b0);
    step(4'b0000, d0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("zext_const", 64'(out_data), 64'(32'h1000_0000));

    // Downstream stall for 5 cycles, then drain and load together.
    step('1, d, '0, '1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step('1, d, '0, '1, 1'b0, 1'b0);
    step('1, d, '0, '1, 1'b1, 1'b0);
    step('1, d, '0, '1, 1'b1, 1'b0);

    // Reset on the second beat of a 4-beat locked packet.
    step('0, d, '0, '0, 1'b1, 1'b1);
    step(4'b0100, d, '0, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, d, '0, 4'b0000, 1'b1, 1'b1);
    step('1, d, '0, '1, 1'b1, 1'b0);
    step('1, d, '0, '1, 1'b1, 1'b0);
    chk("restart_src0", 64'(out_src), 64'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v, sg, l;
      for (int i = 0; i < N; i++) d[i*IW +: IW] = IW'($urandom);
      v  = N'($urandom);
      sg = N'($urandom);
      l  = N'($urandom) | N'($urandom);
      step(v, d, sg, l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end
    step('0, d, '0, '0, 1'b1, 1'b0);
    step('0, d, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
